spi_sub_rx: RTL and testbench
=============================

SPI_SUB_RX -- requirements
Module: spi_sub_rx

Interface
REQ-001 Parameter WORD_WIDTH, default 16, SHALL be the data-word width; the full frame is WORD_WIDTH+2 bits (2 power-state bits, then data).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth on each SPI input pin.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 sclk  input  1  SHALL be the SPI clock from the main, asynchronous to sys_clk.
REQ-006 mosi  input  1  SHALL be serial data, MSB first, valid at sclk falling edge.
REQ-007 csb  input  1  SHALL be the active-low frame select.
REQ-008 data_out  output  WORD_WIDTH  SHALL be the last good frame's data word.
REQ-009 power_state  output  2  SHALL be the last good frame's two leading bits.
REQ-010 valid  output  1  SHALL be a one-cycle pulse marking a data_out/power_state update.
REQ-011 frame_err  output  1  SHALL be a one-cycle pulse marking a discarded frame.
REQ-012 busy  output  1  SHALL be high while a frame is in progress (state SHIFT).

Function
REQ-013 sclk, mosi, csb SHALL each pass through SYNC_STAGES flops plus one history flop; all edge detection uses synchronized values only.
REQ-014 FSM SHALL have two states: IDLE and SHIFT.
REQ-015 IDLE -> SHIFT on synchronized csb falling edge; bit counter cleared to 0, overflow flag cleared, shift register cleared.
REQ-016 In SHIFT, each synchronized sclk falling edge SHALL shift the synchronized mosi into the LSB of a (WORD_WIDTH+2)-bit shift register and increment the bit counter.
REQ-017 Bit counter SHALL be clog2(WORD_WIDTH+2)+1 bits and saturate at WORD_WIDTH+2; a falling edge at saturation sets the overflow flag and leaves the shift register unchanged.
REQ-018 SHIFT -> IDLE on synchronized csb rising edge.
REQ-019 On that transition, if count == WORD_WIDTH+2 and overflow clear, the next cycle SHALL pulse valid and load power_state = shift_reg[top two bits], data_out = shift_reg[WORD_WIDTH-1:0].
REQ-020 Otherwise (short or long frame) the next cycle SHALL pulse frame_err; data_out and power_state retain prior values.
REQ-021 Latency: valid/frame_err SHALL assert exactly SYNC_STAGES+2 sys_clk cycles after the csb pin rise is first sampled.
REQ-022 valid and frame_err SHALL never assert in the same cycle; each asserts at most once per frame.
REQ-023 sclk edges while in IDLE SHALL be ignored.
REQ-024 Same-cycle synchronized csb rise and sclk fall: csb wins, the sclk edge is not sampled.
REQ-025 Same-cycle synchronized csb fall and sclk fall: frame starts, the sclk edge is not sampled.
REQ-026 A csb falling edge SHALL be recognized in the cycle after a frame ends, allowing back-to-back frames with csb high >= SYNC_STAGES+1 cycles.
REQ-027 Correct operation SHALL be required only for sclk high and low times each >= 2 sys_clk cycles; faster sclk is out of scope.

Reset
REQ-028 While rst is high at a sys_clk edge: state IDLE, counter 0, overflow 0, shift register 0, synchronizers and history flops 1 for sclk/csb and 0 for mosi.
REQ-029 Reset values SHALL be: data_out 0, power_state 0, valid 0, frame_err 0, busy 0.
REQ-030 rst mid-frame SHALL abort the frame with no valid and no frame_err pulse; csb still low after rst release SHALL NOT start a frame until a new csb falling edge.

Verification
REQ-031 rst high 2 cycles -> all outputs 0, busy 0.
REQ-032 18-bit frame, power 2'b01, data 16'hA5C3, sclk period 8 cycles -> single valid pulse SYNC_STAGES+2 cycles after csb rise, data_out 16'hA5C3, power_state 2'b01, frame_err never high.
REQ-033 10-bit frame after REQ-032 -> one frame_err pulse, no valid, data_out stays 16'hA5C3.
REQ-034 20-bit frame -> one frame_err pulse, no valid, outputs unchanged.
REQ-035 sclk toggling 30 edges with csb high -> no valid, no frame_err, busy 0; then rst after 9 bits of a frame, new csb cycle with power 2'b11, data 16'h1234 -> one valid, data_out 16'h1234, power_state 2'b11.
REQ-036 Two frames (16'h0001/2'b00, 16'hFFFF/2'b10) with csb high 4 cycles between -> two valid pulses, outputs match each frame in order.

Source files
------------

// File: rtl/spi_sub_rx.sv
// spi_sub_rx: SPI subordinate receiver for a 2-bit power state plus data word,
// with pin synchronizers, framing checks and one-cycle valid/frame_err pulses.
module spi_sub_rx #(
    parameter int WORD_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  csb,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic [1:0]            power_state,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int FW = WORD_WIDTH + 2;
    localparam int CW = $clog2(FW) + 1;
    localparam logic [CW-1:0] FULL = CW'(FW);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, mosi_sync;
    logic                   sclk_h, csb_h, mosi_h;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed, sclk_fall, csb_fall, csb_rise;
    logic [0:0]             state;
    logic [CW-1:0]          cnt;
    logic                   ovf, done_ok, done_err;
    logic [FW-1:0]          shift_reg;

    wire sclk_s = sclk_sync[SYNC_STAGES-1];
    wire csb_s  = csb_sync[SYNC_STAGES-1];
    wire good   = (cnt == FULL) && !ovf;

    assign busy = (state == SHIFT);

    // fill marks when the chain holds real pin samples again after reset, so a
    // csb held low through reset cannot masquerade as a fresh falling edge
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_sync <= '1;
            csb_sync  <= '1;
            mosi_sync <= '0;
            sclk_h    <= 1'b1;
            csb_h     <= 1'b1;
            mosi_h    <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
            sclk_fall <= 1'b0;
            csb_fall  <= 1'b0;
            csb_rise  <= 1'b0;
        end else begin
            sclk_sync[0] <= sclk;
            csb_sync[0]  <= csb;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                csb_sync[i]  <= csb_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_h    <= sclk_s;
            csb_h     <= csb_s;
            mosi_h    <= mosi_sync[SYNC_STAGES-1];
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (fill[SYNC_STAGES] & csb_s);
            sclk_fall <= sclk_h & ~sclk_s;
            csb_fall  <= csb_h & ~csb_s & armed;
            csb_rise  <= ~csb_h & csb_s;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ovf       <= 1'b0;
            shift_reg <= '0;
            done_ok   <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            done_ok  <= 1'b0;
            done_err <= 1'b0;
            if (state == IDLE) begin
                if (csb_fall) begin
                    state     <= SHIFT;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    shift_reg <= '0;
                end
            end else if (csb_rise) begin
                state    <= IDLE;
                done_ok  <= good;
                done_err <= !good;
            end else if (sclk_fall) begin
                if (cnt == FULL) begin
                    ovf <= 1'b1;
                end else begin
                    shift_reg <= {shift_reg[FW-2:0], mosi_h};
                    cnt       <= cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            data_out    <= '0;
            power_state <= '0;
        end else begin
            valid     <= done_ok;
            frame_err <= done_err;
            if (done_ok) begin
                power_state <= shift_reg[FW-1:FW-2];
                data_out    <= shift_reg[WORD_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_spi_sub_rx.sv
// tb_spi_sub_rx: directed frames; expected results queued at csb rise and
// checked by a monitor whenever valid or frame_err pulses.
module tb_spi_sub_rx;
    localparam int SS = 2;

    typedef struct {
        bit          ok;
        logic [15:0] d;
        logic [1:0]  p;
        int          cyc;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        csb = 1'b1;
    logic [15:0] data_out;
    logic [1:0]  power_state;
    logic        valid, frame_err, busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] last_d = '0;
    logic [1:0]  last_p = '0;

    spi_sub_rx #(.WORD_WIDTH(16), .SYNC_STAGES(SS)) dut (
        .sys_clk(sys_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csb(csb),
        .data_out(data_out), .power_state(power_state),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // bits[n-1] goes out first; only an 18-bit frame is a good one
    task automatic frame(input int n, input logic [31:0] bits, input int gap);
        csb = 1'b0;
        wait_cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
            wait_cyc(4);
        end
        csb = 1'b1;
        if (n == 18) begin
            last_d = bits[15:0];
            last_p = bits[17:16];
        end
        q.push_back('{n == 18, last_d, last_p, cyc + SS + 3});
        mosi = 1'b0;
        wait_cyc(gap);
    endtask

    always @(negedge sys_clk) begin
        if (!rst && (valid || frame_err)) begin
            if (valid && frame_err) chk("valid_and_err", 1, 0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", {valid, frame_err}, 0);
            end else begin
                mon_e = q.pop_front();
                chk("kind_valid", valid, mon_e.ok);
                chk("data_out", data_out, mon_e.d);
                chk("power_state", power_state, mon_e.p);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        wait_cyc(2);
        chk("rst_data", data_out, 0);
        chk("rst_power", power_state, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(6);
        frame(18, {14'h0, 2'b01, 16'hA5C3}, 12);
        frame(10, 32'h155, 12);
        frame(20, 32'hFFFFF, 12);
        for (int i = 0; i < 30; i++) begin
            sclk = ~sclk;
            wait_cyc(4);
            if (i == 15) chk("idle_busy", busy, 0);
        end
        sclk = 1'b0;
        wait_cyc(8);
        csb = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 9; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
            wait_cyc(4);
        end
        chk("mid_frame_busy", busy, 1);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        last_d = '0;
        last_p = '0;
        wait_cyc(12);
        chk("post_rst_busy_csb_low", busy, 0);
        chk("post_rst_data", data_out, 0);
        chk("post_rst_power", power_state, 0);
        csb = 1'b1;
        mosi = 1'b0;
        wait_cyc(8);
        frame(18, {14'h0, 2'b11, 16'h1234}, 12);
        frame(18, {14'h0, 2'b00, 16'h0001}, 4);
        frame(18, {14'h0, 2'b10, 16'hFFFF}, 20);
        chk("pending_expected", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
